led_fader: RTL and testbench

Parametrised multi-channel LED brightness engine driving PWM outputs directly to board LED pins. Each channel is independently off, static, breathing (triangle fade with optional per-channel phase stagger) or gliding toward a target level at a programmable rate. It sits between the top-level control/register logic and the LED pins, and supersedes the single-channel 8-bit fade counter.

---
 rtl/led_fader_if.sv | 29 ++
 rtl/led_fader.sv | 137 +++++++++++++
 tb/tb_led_fader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_fader_if.sv
// led_fader control/drive bundle.
// Master = register logic, slave = fader engine.
interface led_fader_if #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8,
  parameter int DIV_BITS = 16
);
  logic [DIV_BITS-1:0]       step_div;
  logic [2*CHANNELS-1:0]     mode;
  logic [WIDTH*CHANNELS-1:0] level;
  logic [CHANNELS-1:0]       pwm_out;
  logic                      period_start;

  modport master (
    output step_div,
    output mode,
    output level,
    input  pwm_out,
    input  period_start
  );

  modport slave (
    input  step_div,
    input  mode,
    input  level,
    output pwm_out,
    output period_start
  );
endinterface

// File: rtl/led_fader.sv
// Multi-channel LED brightness engine:
// off / static / breathe / glide, PWM driven.
module led_fader #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8,
  parameter int DIV_BITS = 16,
  parameter int STAGGER  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  led_fader_if.slave bus
);
  localparam int RW   = WIDTH + 1;
  localparam int SPAN = (1 << RW) / CHANNELS;
  localparam logic [WIDTH-1:0] PWM_LAST =
    WIDTH'((1 << WIDTH) - 2);

  logic [DIV_BITS-1:0] presc;
  logic                tick;
  logic [WIDTH:0]      ramp;
  logic [WIDTH-1:0]    pwm_ctr;
  logic                pwm_zero;

  logic [WIDTH:0]   phase    [CHANNELS];
  logic [WIDTH-1:0] lvl      [CHANNELS];
  logic [WIDTH-1:0] brth     [CHANNELS];
  logic [WIDTH-1:0] cur      [CHANNELS];
  logic [WIDTH-1:0] cur_nxt  [CHANNELS];
  logic [WIDTH-1:0] duty     [CHANNELS];
  logic [WIDTH-1:0] duty_eff [CHANNELS];

  logic [CHANNELS-1:0] pwm_nxt;
  logic [CHANNELS-1:0] pwm_q;
  logic                ps_q;

  assign tick     = (presc == bus.step_div);
  assign pwm_zero = (pwm_ctr == '0);

  // Step prescaler; a shrunk divider wraps through all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + DIV_BITS'(1);
    end
  end

  // Shared breathe ramp, one step per tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp <= '0;
    end else if (tick) begin
      ramp <= ramp + RW'(1);
    end
  end

  // PWM counter 0..2^WIDTH-2 so all-ones duty is fully on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_ctr <= '0;
    end else if (pwm_ctr == PWM_LAST) begin
      pwm_ctr <= '0;
    end else begin
      pwm_ctr <= pwm_ctr + WIDTH'(1);
    end
  end

  // Per-channel brightness target for the next tick.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      lvl[i]   = bus.level[WIDTH*i +: WIDTH];
      phase[i] = ramp + RW'(STAGGER != 0 ? i * SPAN : 0);
      brth[i]  = phase[i][WIDTH] ? ~phase[i][WIDTH-1:0]
                                 :  phase[i][WIDTH-1:0];
      cur_nxt[i] = cur[i];
      unique case (bus.mode[2*i +: 2])
        2'b00: cur_nxt[i] = '0;
        2'b01: cur_nxt[i] = lvl[i];
        2'b10: cur_nxt[i] = brth[i];
        2'b11: begin
          if (cur[i] < lvl[i]) begin
            cur_nxt[i] = cur[i] + WIDTH'(1);
          end else if (cur[i] > lvl[i]) begin
            cur_nxt[i] = cur[i] - WIDTH'(1);
          end
        end
      endcase
    end
  end

  // Brightness registers advance only on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cur[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cur[i] <= cur_nxt[i];
      end
    end
  end

  // Compare against the duty that holds for this period,
  // including the one being latched at the boundary.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_eff[i] = pwm_zero ? cur[i] : duty[i];
      pwm_nxt[i]  = (duty_eff[i] > pwm_ctr);
    end
  end

  // Duty latch at period boundary and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty[i] <= '0;
      end
      pwm_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      if (pwm_zero) begin
        for (int i = 0; i < CHANNELS; i++) begin
          duty[i] <= cur[i];
        end
      end
      pwm_q <= pwm_nxt;
      ps_q  <= pwm_zero;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = ps_q;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader:
// static table, breathe, glide, latch, divider, reset.
module tb_led_fader;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int DB = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  led_fader_if #(
    .CHANNELS(CH), .WIDTH(W), .DIV_BITS(DB)
  ) bus ();

  led_fader #(
    .CHANNELS(CH), .WIDTH(W),
    .DIV_BITS(DB), .STAGGER(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mode;
    logic [31:0] level;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [4];
  int   n_vec = 0;
  int   n_bad = 0;
  int   hi [CH];

  task automatic check(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic check_rng(string nm, int act,
                           int lo, int hi_b);
    n_vec++;
    if (act < lo || act > hi_b) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d",
               nm, act, lo, hi_b);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int tri_f(int p);
    int q;
    q = p % 512;
    return (q >= 256) ? 511 - q : q;
  endfunction

  // Advance to the first cycle of the next PWM period.
  task automatic wait_ps(string nm);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (bus.period_start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check(nm, 0, 1);
  endtask

  // High cycles per channel over one full PWM period.
  task automatic measure(string nm);
    for (int i = 0; i < CH; i++) hi[i] = 0;
    wait_ps(nm);
    for (int c = 0; c < 255; c++) begin
      if (c > 0) @(negedge clk);
      for (int i = 0; i < CH; i++)
        hi[i] += int'(bus.pwm_out[i]);
    end
  endtask

  initial begin
    int reach, prev, cval, bad, first;

    vt[0] = '{8'h55, {8'd255, 8'd128, 8'd1, 8'd0},
                     {8'd255, 8'd128, 8'd1, 8'd0}};
    vt[1] = '{8'h55, {8'd17, 8'd3, 8'd200, 8'd255},
                     {8'd17, 8'd3, 8'd200, 8'd255}};
    vt[2] = '{8'h44, {8'd2, 8'd200, 8'd254, 8'd77},
                     {8'd2, 8'd0, 8'd254, 8'd0}};
    vt[3] = '{8'h55, {8'd254, 8'd0, 8'd64, 8'd127},
                     {8'd254, 8'd0, 8'd64, 8'd127}};

    // Reset state and first period_start pulses.
    bus.step_div = '0;
    bus.mode     = vt[0].mode;
    bus.level    = vt[0].level;
    cyc(3);
    check("rst_pwm", int'(bus.pwm_out), 0);
    check("rst_ps", int'(bus.period_start), 0);
    rst_n = 1'b1;
    cyc(1);
    check("ps_cyc1", int'(bus.period_start), 1);
    check("pwm_cyc1", int'(bus.pwm_out), 0);
    cyc(1);
    check("ps_cyc2", int'(bus.period_start), 0);
    cyc(254);
    check("ps_cyc256", int'(bus.period_start), 1);

    // Static/off table.
    for (int v = 0; v < 4; v++) begin
      bus.mode  = vt[v].mode;
      bus.level = vt[v].level;
      wait_ps("sync_tmo");
      measure("meas_tmo");
      for (int i = 0; i < CH; i++)
        check($sformatf("static_v%0d_ch%0d", v, i),
              hi[i], int'(vt[v].exp[8*i +: 8]));
    end

    // Breathe with stagger from a fresh reset.
    rst_n = 1'b0;
    bus.mode = 8'hAA;
    bus.step_div = '0;
    cyc(2);
    rst_n = 1'b1;
    begin
      int pts [8] = '{1, 2, 129, 256, 257, 258, 385, 513};
      int k;
      k = 0;
      for (int j = 0; j < 8; j++) begin
        while (k < pts[j]) begin
          @(negedge clk);
          k++;
        end
        for (int i = 0; i < CH; i++)
          check($sformatf("brth_k%0d_ch%0d", k, i),
                int'(dut.cur[i]), tri_f(k - 1 + 128 * i));
      end
    end

    // Asynchronous reset pulse between clock edges.
    wait_ps("brth_ps_tmo");
    cyc(2);
    check("brth_on", int'(bus.pwm_out != '0), 1);
    #2 rst_n = 1'b0;
    #1 check("arst_pwm", int'(bus.pwm_out), 0);
    check("arst_ps", int'(bus.period_start), 0);
    #1 rst_n = 1'b1;
    check("arst_ramp", int'(dut.ramp), 0);
    for (int i = 0; i < CH; i++) begin
      check($sformatf("arst_cur%0d", i),
            int'(dut.cur[i]), 0);
      check($sformatf("arst_duty%0d", i),
            int'(dut.duty[i]), 0);
    end

    // Level change mid-period waits for the boundary.
    @(negedge clk);
    bus.mode  = 8'h55;
    bus.level = '0;
    wait_ps("latch_sync");
    wait_ps("latch_sync2");
    cyc(100);
    bus.level = 32'd200;
    reach = int'(bus.pwm_out[0]);
    for (int c = 101; c < 255; c++) begin
      @(negedge clk);
      reach += int'(bus.pwm_out[0]);
    end
    check("latch_old_period", reach, 0);
    measure("latch_meas");
    check("latch_new_period", hi[0], 200);

    // Glide up to 10 then down to 7.
    bus.step_div = DB'(3);
    bus.mode  = 8'h01;
    bus.level = '0;
    cyc(20);
    bus.mode  = 8'h03;
    bus.level = 32'd10;
    reach = 0; prev = 0; bad = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      cval = int'(dut.cur[0]);
      if (cval > 10 || cval - prev > 1 || prev - cval > 1)
        bad++;
      if (cval == 10 && reach == 0) reach = j;
      prev = cval;
    end
    check_rng("glide_up_time", reach, 37, 40);
    check("glide_up_hold", int'(dut.cur[0]), 10);
    check("glide_up_step", bad, 0);
    bus.level = 32'd7;
    reach = 0; bad = 0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      cval = int'(dut.cur[0]);
      if (cval < 7 || prev - cval > 1 || cval > prev)
        bad++;
      if (cval == 7 && reach == 0) reach = j;
      prev = cval;
    end
    check_rng("glide_dn_time", reach, 9, 12);
    check("glide_dn_hold", int'(dut.cur[0]), 7);
    check("glide_dn_step", bad, 0);

    // Divider shrunk below the running count.
    rst_n = 1'b0;
    bus.step_div = DB'(1000);
    cyc(1);
    rst_n = 1'b1;
    cyc(500);
    bus.step_div = DB'(5);
    first = 0;
    for (int j = 1; j <= 4000; j++) begin
      @(negedge clk);
      if (dut.ramp != '0) begin
        first = j;
        break;
      end
    end
    check("div_wrap_tick", first, 3602);
    cyc(6);
    check("div_tick2", int'(dut.ramp), 2);
    cyc(6);
    check("div_tick3", int'(dut.ramp), 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
